// File: rtl/jtag_ahb_master_ctrl_if.sv
// AHB-Lite bus bundle between the JTAG debug master sequencer and the system fabric.
interface jtag_ahb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/jtag_ahb_master_ctrl.sv
// Single-transfer AHB-Lite master for the JTAG debug path: one NONSEQ SINGLE per
// request, with wait-state counting, error capture and auto-incrementing address.
module jtag_ahb_master_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAIT_W = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                ahb_enable,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_incr,
    input  logic                cmd_write,
    input  logic [2:0]          cmd_size,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                ack,
    output logic                busy,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic [WAIT_W-1:0]   wait_cnt,
    jtag_ahb_master_ctrl_if.master ahb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ACK  = 2'b11
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   next_addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                skip_r;
    logic [ADDR_W-1:0]   addr_s;
    logic                misalign_s;

    function automatic logic misaligned(input logic [1:0] a_lo, input logic [2:0] sz);
        case (sz)
            3'd0:    return 1'b0;
            3'd1:    return a_lo[0];
            3'd2:    return a_lo[1] | a_lo[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v == {WAIT_W{1'b1}}) return v;
        else                     return v + WAIT_W'(1);
    endfunction

    // Command address selection and alignment check
    always_comb begin
        if (cmd_incr) addr_s = next_addr_r;
        else          addr_s = cmd_addr;
        misalign_s = misaligned(addr_s[1:0], cmd_size);
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Next-state logic; a rejected command still spends one cycle in ADDR
    // without driving NONSEQ so completion timing is uniform.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ahb_enable) state_s = ST_ADDR;
                else            state_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (skip_r)          state_s = ST_ACK;
                else if (ahb.HREADY) state_s = ST_DATA;
                else                 state_s = ST_ADDR;
            end
            ST_DATA: begin
                if (ahb.HREADY) state_s = ST_ACK;
                else            state_s = ST_DATA;
            end
            ST_ACK:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    assign ack        = (state_r == ST_ACK);
    assign busy       = (state_r != ST_IDLE);
    assign ahb.HBURST = 3'b000;

    // Bus outputs, status and address tracking
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ahb.HADDR   <= {ADDR_W{1'b0}};
            ahb.HTRANS  <= 2'b00;
            ahb.HWRITE  <= 1'b0;
            ahb.HSIZE   <= 3'b000;
            ahb.HWDATA  <= {DATA_W{1'b0}};
            rdata       <= {DATA_W{1'b0}};
            err         <= 1'b0;
            wait_cnt    <= {WAIT_W{1'b0}};
            next_addr_r <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            skip_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ahb_enable) begin
                        wait_cnt <= {WAIT_W{1'b0}};
                        err      <= misalign_s;
                        skip_r   <= misalign_s;
                        wdata_r  <= cmd_wdata;
                        if (!misalign_s) begin
                            ahb.HTRANS <= 2'b10;
                            ahb.HADDR  <= addr_s;
                            ahb.HWRITE <= cmd_write;
                            ahb.HSIZE  <= cmd_size;
                        end
                    end
                end
                ST_ADDR: begin
                    if (!skip_r) begin
                        if (ahb.HREADY) begin
                            ahb.HTRANS <= 2'b00;
                            if (ahb.HWRITE) ahb.HWDATA <= wdata_r;
                        end else begin
                            wait_cnt <= sat_inc(wait_cnt);
                        end
                    end
                end
                ST_DATA: begin
                    if (ahb.HREADY) begin
                        err <= ahb.HRESP;
                        if (!ahb.HRESP) begin
                            if (!ahb.HWRITE) rdata <= ahb.HRDATA;
                            next_addr_r <= ahb.HADDR + (ADDR_W'(1) << ahb.HSIZE);
                        end
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_ahb_master_ctrl.sv
// Bench for jtag_ahb_master_ctrl: transaction-level model fills a per-cycle
// expectation table that a single compare process checks on the falling edge.
module tb_jtag_ahb_master_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ahb_enable;
    logic [31:0] cmd_addr;
    logic        cmd_incr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        ack;
    logic        busy;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  wait_cnt;

    jtag_ahb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    jtag_ahb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .ahb_enable(ahb_enable),
        .cmd_addr(cmd_addr), .cmd_incr(cmd_incr), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .ack(ack), .busy(busy), .rdata(rdata), .err(err), .wait_cnt(wait_cnt),
        .ahb(bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    localparam int N = 4096;
    bit          exp_valid [N];
    bit          exp_ack   [N];
    bit          exp_busy  [N];
    logic [1:0]  exp_htrans[N];
    bit          exp_nonseq[N];
    logic [31:0] exp_haddr [N];
    bit          exp_hwrite[N];
    logic [2:0]  exp_hsize [N];
    bit          exp_hwd_v [N];
    logic [31:0] exp_hwd   [N];
    bit          exp_err   [N];
    logic [7:0]  exp_wait  [N];
    logic [31:0] exp_rdata [N];

    logic [31:0] m_next_addr = 32'h0;
    logic [31:0] m_rdata     = 32'h0;

    int n_total = 0;
    int n_pass  = 0;
    int lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, expv);
    endtask

    task automatic set_exp(input int c, input bit b, input bit a, input logic [1:0] tr);
        exp_valid[c]  = 1'b1;
        exp_busy[c]   = b;
        exp_ack[c]    = a;
        exp_htrans[c] = tr;
    endtask

    // Called #1 after a rising edge; returns cycles from request to ack.
    task automatic txn(input logic [31:0] a, input bit incr, input bit wr,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input int aw, input int dw, input bit resp,
                       input logic [31:0] rd, output int latency);
        int e, k, t, p, j;
        logic [31:0] addr;
        bit mis, done;
        e = cyc;
        k = e + 1;
        addr = incr ? m_next_addr : a;
        mis = (sz > 3'd2) || ((addr % (32'd1 << sz)) != 32'd0);
        if (mis) begin
            set_exp(k, 1'b1, 1'b0, 2'b00);
            t = k + 1;
            exp_err[t]  = 1'b1;
            exp_wait[t] = 8'd0;
        end else begin
            for (int i = 0; i <= aw; i++) begin
                set_exp(k + i, 1'b1, 1'b0, 2'b10);
                exp_nonseq[k + i] = 1'b1;
                exp_haddr[k + i]  = addr;
                exp_hwrite[k + i] = wr;
                exp_hsize[k + i]  = sz;
            end
            for (int i = 0; i <= dw; i++) begin
                set_exp(k + aw + 1 + i, 1'b1, 1'b0, 2'b00);
                exp_hwd_v[k + aw + 1 + i] = wr;
                exp_hwd[k + aw + 1 + i]   = wd;
            end
            t = k + aw + dw + 2;
            if (!resp) begin
                if (!wr) m_rdata = rd;
                m_next_addr = addr + (32'd1 << sz);
            end
            exp_err[t]  = resp;
            exp_wait[t] = (aw + dw > 255) ? 8'd255 : 8'(aw + dw);
        end
        set_exp(t, 1'b1, 1'b1, 2'b00);
        exp_rdata[t] = m_rdata;
        set_exp(t + 1, 1'b0, 1'b0, 2'b00);

        ahb_enable = 1'b1; cmd_addr = a; cmd_incr = incr; cmd_write = wr;
        cmd_size = sz; cmd_wdata = wd;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = rd;
        latency = -1;
        done = 1'b0;
        for (int c = 0; c < aw + dw + 12 && !done; c++) begin
            @(posedge CLK); #1;
            if (ack) begin
                latency = cyc - e;
                done = 1'b1;
            end else if (!mis) begin
                p = cyc - k;
                if (p <= aw) begin
                    bus.HREADY = (p == aw);
                    bus.HRESP  = 1'b0;
                end else begin
                    j = p - aw - 1;
                    bus.HREADY = (j >= dw);
                    bus.HRESP  = resp;
                end
            end
        end
        if (done) begin
            @(posedge CLK); #1;
        end else begin
            chk("ack_timeout", 32'(latency), 32'(t - e));
        end
        ahb_enable = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    endtask

    // Per-cycle comparison of DUT outputs against the model's expectation table
    always @(negedge CLK) begin
        if (nRST && cyc < N && exp_valid[cyc]) begin
            chk("ack", ack, exp_ack[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("htrans", bus.HTRANS, exp_htrans[cyc]);
            chk("hburst", bus.HBURST, 3'b000);
            if (exp_nonseq[cyc]) begin
                chk("haddr", bus.HADDR, exp_haddr[cyc]);
                chk("hwrite", bus.HWRITE, exp_hwrite[cyc]);
                chk("hsize", bus.HSIZE, exp_hsize[cyc]);
            end
            if (exp_hwd_v[cyc]) chk("hwdata", bus.HWDATA, exp_hwd[cyc]);
            if (exp_ack[cyc]) begin
                chk("err", err, exp_err[cyc]);
                chk("wait_cnt", wait_cnt, exp_wait[cyc]);
                chk("rdata", rdata, exp_rdata[cyc]);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_htrans"}, bus.HTRANS, 2'b00);
        chk({tag, "_haddr"}, bus.HADDR, 32'h0);
        chk({tag, "_hwrite"}, bus.HWRITE, 1'b0);
        chk({tag, "_hsize"}, bus.HSIZE, 3'b000);
        chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
        chk({tag, "_hburst"}, bus.HBURST, 3'b000);
        chk({tag, "_ack"}, ack, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_wait"}, wait_cnt, 8'd0);
    endtask

    initial begin
        nRST = 1'b0; ahb_enable = 1'b0; cmd_addr = 32'h0; cmd_incr = 1'b0;
        cmd_write = 1'b0; cmd_size = 3'd0; cmd_wdata = 32'h0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_vals("reset");
        nRST = 1'b1;
        @(posedge CLK); #1;

        txn(32'h0000_1000, 1'b0, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, lat);
        chk("wr0_lat", 32'(lat), 32'd3);
        chk("wr0_err", err, 1'b0);
        chk("wr0_wait", wait_cnt, 8'd0);
        chk("wr0_hwdata", bus.HWDATA, 32'hDEAD_BEEF);

        txn(32'h0000_2000, 1'b0, 1'b0, 3'd2, 32'h0, 0, 3, 1'b0, 32'h1234_5678, lat);
        chk("rd3_lat", 32'(lat), 32'd6);
        chk("rd3_rdata", rdata, 32'h1234_5678);
        chk("rd3_wait", wait_cnt, 8'd3);

        txn(32'hFFFF_FFFC, 1'b0, 1'b1, 3'd2, 32'h1111_1111, 0, 0, 1'b0, 32'h0, lat);
        txn(32'h0000_ABC0, 1'b1, 1'b1, 3'd2, 32'h2222_2222, 0, 0, 1'b0, 32'h0, lat);
        chk("wrap_haddr", bus.HADDR, 32'h0000_0000);
        chk("wrap_lat", 32'(lat), 32'd3);

        txn(32'h0, 1'b1, 1'b0, 3'd2, 32'h0, 0, 1, 1'b1, 32'h9999_9999, lat);
        chk("err_flag", err, 1'b1);
        chk("err_rdata", rdata, 32'h1234_5678);
        chk("err_wait", wait_cnt, 8'd1);
        chk("err_haddr", bus.HADDR, 32'h0000_0004);

        txn(32'h0, 1'b1, 1'b0, 3'd0, 32'h0, 2, 0, 1'b0, 32'h0000_00A5, lat);
        chk("aw_haddr", bus.HADDR, 32'h0000_0004);
        chk("aw_rdata", rdata, 32'h0000_00A5);
        chk("aw_wait", wait_cnt, 8'd2);
        chk("aw_lat", 32'(lat), 32'd5);

        txn(32'h0, 1'b1, 1'b0, 3'd1, 32'h0, 0, 0, 1'b0, 32'h0, lat);
        chk("mis_incr_lat", 32'(lat), 32'd2);
        chk("mis_incr_err", err, 1'b1);

        txn(32'h0000_1002, 1'b0, 1'b1, 3'd2, 32'h3333_3333, 0, 0, 1'b0, 32'h0, lat);
        chk("mis_lat", 32'(lat), 32'd2);
        chk("mis_err", err, 1'b1);
        chk("mis_wait", wait_cnt, 8'd0);

        txn(32'h0000_1000, 1'b0, 1'b0, 3'd3, 32'h0, 0, 0, 1'b0, 32'h0, lat);
        chk("sz3_lat", 32'(lat), 32'd2);
        chk("sz3_err", err, 1'b1);

        txn(32'h0, 1'b1, 1'b1, 3'd0, 32'h0000_0044, 0, 0, 1'b0, 32'h0, lat);
        chk("after_mis_haddr", bus.HADDR, 32'h0000_0005);
        chk("after_mis_err", err, 1'b0);

        txn(32'h0000_3000, 1'b0, 1'b0, 3'd2, 32'h0, 0, 260, 1'b0, 32'h5A5A_5A5A, lat);
        chk("sat_wait", wait_cnt, 8'd255);
        chk("sat_lat", 32'(lat), 32'd263);

        ahb_enable = 1'b1; cmd_addr = 32'h0000_3000; cmd_incr = 1'b0;
        cmd_write = 1'b0; cmd_size = 3'd2; bus.HREADY = 1'b0;
        @(posedge CLK); #1;
        chk("rst_pre_htrans", bus.HTRANS, 2'b10);
        @(posedge CLK); #1;
        nRST = 1'b0; ahb_enable = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge CLK); #1;
        chk("midrst_hold_htrans", bus.HTRANS, 2'b00);
        nRST = 1'b1; bus.HREADY = 1'b1;
        m_next_addr = 32'h0;
        m_rdata     = 32'h0;
        @(posedge CLK); #1;

        txn(32'h0000_7777, 1'b1, 1'b0, 3'd2, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D, lat);
        chk("post_rst_haddr", bus.HADDR, 32'h0000_0000);
        chk("post_rst_rdata", rdata, 32'hCAFE_F00D);
        chk("post_rst_lat", 32'(lat), 32'd3);

        repeat (2) @(posedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
